// File: rtl/membus_arbiter_rv32_if.sv
`default_nettype none
// ============================================================================
// Module   : membus_arbiter_rv32_if
// Brief    : Fetch, data and external-bus signal bundle for membus_arbiter_rv32.
// Revision : 1.0
// ============================================================================
interface membus_arbiter_rv32_if;
    logic        iIF_REQ;
    logic [29:0] iIF_ADDR;
    logic        oIF_ACK;
    logic [31:0] oIF_DATA;
    logic        oIF_ERR;
    logic        iD_REQ;
    logic        iD_RW;
    logic [31:0] iD_ADDR;
    logic [31:0] iD_WDATA;
    logic [1:0]  iD_SIZE;
    logic        oD_ACK;
    logic [31:0] oD_RDATA;
    logic        oD_ERR;
    logic        oBUS_REQ;
    logic        oBUS_RW;
    logic [29:0] oBUS_ADDR;
    logic [31:0] oBUS_WDATA;
    logic [3:0]  oBUS_BE;
    logic        iBUS_ACK;
    logic [31:0] iBUS_RDATA;
    logic        oBUSY;

    modport slave (
        input  iIF_REQ, iIF_ADDR, iD_REQ, iD_RW, iD_ADDR, iD_WDATA, iD_SIZE,
               iBUS_ACK, iBUS_RDATA,
        output oIF_ACK, oIF_DATA, oIF_ERR, oD_ACK, oD_RDATA, oD_ERR,
               oBUS_REQ, oBUS_RW, oBUS_ADDR, oBUS_WDATA, oBUS_BE, oBUSY
    );

    modport master (
        output iIF_REQ, iIF_ADDR, iD_REQ, iD_RW, iD_ADDR, iD_WDATA, iD_SIZE,
               iBUS_ACK, iBUS_RDATA,
        input  oIF_ACK, oIF_DATA, oIF_ERR, oD_ACK, oD_RDATA, oD_ERR,
               oBUS_REQ, oBUS_RW, oBUS_ADDR, oBUS_WDATA, oBUS_BE, oBUSY
    );
endinterface
`default_nettype wire

// File: rtl/membus_arbiter_rv32.sv
`default_nettype none
// ============================================================================
// Module   : membus_arbiter_rv32
// Brief    : Shares one req/ack memory bus between fetch and the data port,
//            with data priority, starvation guard, lane steering and timeout.
// Revision : 1.0
// ============================================================================
module membus_arbiter_rv32 #(
    parameter int TIMEOUT = 255,
    parameter int FAIRCNT = 4
) (
    input  wire logic            iCLK,
    input  wire logic            iRSTn,
    membus_arbiter_rv32_if.slave bus
);
    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam int          FW       = $clog2(FAIRCNT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FAIR_MAX = FW'(FAIRCNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DBUS = 2'd1,
        S_IBUS = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] starv_q, starv_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic          req_q, req_d;
    logic          rw_q, rw_d;
    logic [29:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          if_ack_q, if_ack_d;
    logic          if_err_q, if_err_d;
    logic [31:0]   if_data_q, if_data_d;
    logic          d_ack_q, d_ack_d;
    logic          d_err_q, d_err_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic          w_if_elig, w_d_elig, w_starved, w_misal;
    logic [3:0]    w_lane_be;
    logic [31:0]   w_lane_wdata, w_shift, w_load;

    // A requester whose ack is showing this cycle is still holding its old request.
    assign w_if_elig = bus.iIF_REQ & ~if_ack_q;
    assign w_d_elig  = bus.iD_REQ  & ~d_ack_q;
    assign w_starved = (starv_q == FAIR_MAX);
    assign w_misal   = (bus.iD_SIZE == 2'b11)
                    || ((bus.iD_SIZE == 2'b01) && bus.iD_ADDR[0])
                    || ((bus.iD_SIZE == 2'b10) && (bus.iD_ADDR[1:0] != 2'b00));

    always_comb begin
        w_lane_be    = 4'b1111;
        w_lane_wdata = bus.iD_WDATA;
        case (bus.iD_SIZE)
            2'b00: begin
                w_lane_be    = 4'b0001 << bus.iD_ADDR[1:0];
                w_lane_wdata = {4{bus.iD_WDATA[7:0]}};
            end
            2'b01: begin
                w_lane_be    = bus.iD_ADDR[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{bus.iD_WDATA[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_shift = bus.iBUS_RDATA >> {off_q, 3'b000};
        case (size_q)
            2'b00:   w_load = {24'd0, w_shift[7:0]};
            2'b01:   w_load = {16'd0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        starv_d   = starv_q;
        tmo_d     = tmo_q;
        size_d    = size_q;
        off_d     = off_q;
        req_d     = req_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        if_ack_d  = 1'b0;
        if_err_d  = 1'b0;
        if_data_d = if_data_q;
        d_ack_d   = 1'b0;
        d_err_d   = 1'b0;
        d_rdata_d = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (w_d_elig && !(w_if_elig && w_starved)) begin
                    size_d = bus.iD_SIZE;
                    off_d  = bus.iD_ADDR[1:0];
                    if (bus.iIF_REQ && !w_starved) starv_d = starv_q + FW'(1);
                    if (w_misal) begin
                        state_d   = S_RESP;
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        state_d = S_DBUS;
                        req_d   = 1'b1;
                        rw_d    = bus.iD_RW;
                        addr_d  = bus.iD_ADDR[31:2];
                        wdata_d = w_lane_wdata;
                        be_d    = bus.iD_RW ? 4'b1111 : w_lane_be;
                    end
                end else if (w_if_elig) begin
                    starv_d = '0;
                    state_d = S_IBUS;
                    req_d   = 1'b1;
                    rw_d    = 1'b1;
                    addr_d  = bus.iIF_ADDR;
                    be_d    = 4'b1111;
                end
            end
            S_DBUS, S_IBUS: begin
                // An ack arriving on the last allowed cycle still completes normally.
                if (bus.iBUS_ACK || (tmo_q == TMO_LAST)) begin
                    req_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = S_RESP;
                    if (state_q == S_DBUS) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = ~bus.iBUS_ACK;
                        d_rdata_d = (bus.iBUS_ACK && rw_q) ? w_load : '0;
                    end else begin
                        if_ack_d  = 1'b1;
                        if_err_d  = ~bus.iBUS_ACK;
                        if_data_d = bus.iBUS_ACK ? bus.iBUS_RDATA : '0;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                tmo_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q   <= S_IDLE;
            starv_q   <= '0;
            tmo_q     <= '0;
            size_q    <= '0;
            off_q     <= '0;
            req_q     <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            if_ack_q  <= 1'b0;
            if_err_q  <= 1'b0;
            if_data_q <= '0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starv_q   <= starv_d;
            tmo_q     <= tmo_d;
            size_q    <= size_d;
            off_q     <= off_d;
            req_q     <= req_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            if_ack_q  <= if_ack_d;
            if_err_q  <= if_err_d;
            if_data_q <= if_data_d;
            d_ack_q   <= d_ack_d;
            d_err_q   <= d_err_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.oIF_ACK    = if_ack_q;
    assign bus.oIF_ERR    = if_err_q;
    assign bus.oIF_DATA   = if_data_q;
    assign bus.oD_ACK     = d_ack_q;
    assign bus.oD_ERR     = d_err_q;
    assign bus.oD_RDATA   = d_rdata_q;
    assign bus.oBUS_REQ   = req_q;
    assign bus.oBUS_RW    = rw_q;
    assign bus.oBUS_ADDR  = addr_q;
    assign bus.oBUS_WDATA = wdata_q;
    assign bus.oBUS_BE    = be_q;
    assign bus.oBUSY      = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: doc/membus_arbiter_rv32.md
# membus_arbiter_rv32

Shares the single external memory bus between instruction fetch and the EX-stage data port (loads/stores). Arbitrates between the two requesters with data priority and a starvation guard, and runs one outstanding bus transaction at a time over a req/ack handshake. It generates byte enables and store-lane replication, checks data alignment, and aborts stalled transactions on timeout. Registered outputs throughout; it sits between the pipeline stages and the memory/peripheral interconnect.

## Interface
- TIMEOUT, 255: max cycles oBUS_REQ may stay high without iBUS_ACK (≥2).
- FAIRCNT, 4: consecutive data grants while fetch waits before fetch is forced through (≥1).
- iCLK  in  1  clock, rising edge.
- iRSTn  in  1  asynchronous, active-low reset.
- iIF_REQ  in  1  fetch request; held with iIF_ADDR until oIF_ACK.
- iIF_ADDR  in  30  fetch word address [31:2].
- oIF_ACK  out  1  one-cycle completion pulse.
- oIF_DATA  out  32  fetched word, valid with oIF_ACK.
- oIF_ERR  out  1  timeout, valid with oIF_ACK.
- iD_REQ  in  1  data request; held with all iD_* until oD_ACK.
- iD_RW  in  1  1 = read, 0 = write.
- iD_ADDR  in  32  byte address.
- iD_WDATA  in  32  store data, low-aligned.
- iD_SIZE  in  2  00 byte, 01 half, 10 word, 11 invalid.
- oD_ACK  out  1  one-cycle completion pulse.
- oD_RDATA  out  32  load data shifted to bit 0, zero-extended; 0 on error or write.
- oD_ERR  out  1  misaligned, invalid size or timeout, valid with oD_ACK.
- oBUS_REQ  out  1  bus request; fields stable while high.
- oBUS_RW  out  1  1 = read.
- oBUS_ADDR  out  30  word address.
- oBUS_WDATA  out  32  lane-replicated store data.
- oBUS_BE  out  4  byte enables; 1111 for reads.
- iBUS_ACK  in  1  completion; sampled only while oBUS_REQ = 1.
- iBUS_RDATA  in  32  read word, valid with iBUS_ACK.
- oBUSY  out  1  state ≠ IDLE.

## Operation
- States: IDLE, DBUS (data transaction in flight), IBUS (fetch in flight), RESP (one-cycle ack/err issue).
- IDLE grant: a requester is eligible if its REQ = 1 and its ACK is not high this cycle; a REQ seen in the ack cycle is masked.
- Both eligible: data wins unless the starvation counter = FAIRCNT, then fetch wins.
- Starvation counter: +1 on each data grant made while iIF_REQ = 1; cleared on fetch grant; saturates at FAIRCNT.
- Data check at grant: iD_SIZE = 11, half with addr[0] = 1, or word with addr[1:0] ≠ 0 → no bus cycle; go to RESP with err.
- Byte enables: byte → 0001 << addr[1:0], WDATA = byte×4; half → addr[1] ? 1100 : 0011, WDATA = half×2; word → 1111.
- Read extraction: word >> (8·addr[1:0]), masked to 8/16/32 bits.
- DBUS/IBUS: oBUS_REQ = 1; timeout counter increments each cycle. iBUS_ACK → latch data, go to RESP. Counter reaches TIMEOUT-1 without ack → drop oBUS_REQ, go to RESP with err, data 0.
- RESP: pulse the owner's ACK (plus ERR if set); clear the counter; return to IDLE.
- Reset (async, any state): all outputs 0, state IDLE, counters 0. An in-flight transaction is discarded and no ACK is issued.

## Timing
- Grant sampled at edge N; oBUS_REQ high from N+1.
- iBUS_ACK at edge K → oX_ACK/data high for cycle K+1 and oBUS_REQ low at K+1.
- Minimum successful latency: request to ACK = 3 cycles with zero-wait bus (ack in first oBUS_REQ cycle).
- Misaligned: ACK+ERR 2 cycles after request; oBUS_REQ never rises.
- Back-to-back, same requester: next grant sampled at K+2 (ack-cycle mask). Other requester: can be granted at K+2.
- Timeout: oBUS_REQ high for exactly TIMEOUT cycles; the abort response follows.

## Test plan
- Zero-wait fetch: iIF_ADDR=0x0000_0100>>2, bus acks the first cycle with 0x0000_0013 → oIF_ACK at cycle 3, oIF_DATA=0x13, oBUS_BE=1111.
- Store byte: iD_ADDR=0x1003, iD_WDATA=0xAB, iD_SIZE=00, write → oBUS_BE=1000, oBUS_WDATA=0xABABABAB, oBUS_ADDR=0x400.
- Load half: iD_ADDR=0x2002, bus word 0xBEEF1234 → oD_RDATA=0x0000BEEF. Repeat with iD_ADDR=0x2001 → oD_ACK+oD_ERR, no oBUS_REQ.
- Contention: both REQ held continuously, FAIRCNT=4 → grant order D,D,D,D,F,D,D,D,D,F; no grant issued in any requester's ack cycle.
- Timeout: TIMEOUT=8, bus never acks → oBUS_REQ high 8 cycles, then oD_ACK=oD_ERR=1, oD_RDATA=0; a late iBUS_ACK while oBUS_REQ=0 is ignored.
- Reset mid-DBUS: drive iRSTn low between edges → outputs 0 immediately, no ACK; after release, a fresh fetch completes normally.
